// File: rtl/mixer_tree_scheduler_pkg.sv
// Shared types and constants for the mixing-tree scheduler.
package mfda_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        MIX_LEAF = 3'd2,
        XFER     = 3'd3,
        MIX_ROOT = 3'd4,
        FLUSH    = 3'd5
    } phase_e;

    localparam int unsigned LEAVES_PER_TREE   = 4;
    localparam int unsigned MIXERS_PER_LEVEL1 = 2;

    // A zero-length phase would never terminate cleanly, so it runs for one cycle.
    function automatic int unsigned phase_len(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/mixer_tree_scheduler_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             grant_valid
);

    // Scan the requesters starting from the pointer and keep the first hit.
    always_comb begin
        int unsigned idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!grant_valid && req[idx]) begin
                grant       = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mixer_tree_scheduler.sv
// Grants one mixing tree at a time and sequences its valves and mixers
// through LOAD -> MIX_LEAF -> XFER -> MIX_ROOT -> FLUSH.
module mixer_tree_scheduler
    import mfda_sched_pkg::*;
#(
    parameter  int unsigned NUM_TREES    = 4,
    parameter  int unsigned LOAD_CYCLES  = 8,
    parameter  int unsigned MIX_CYCLES   = 16,
    parameter  int unsigned XFER_CYCLES  = 8,
    parameter  int unsigned FLUSH_CYCLES = 8,
    parameter  int unsigned CNT_W        = 8,
    localparam int unsigned IDX_W        = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_TREES-1:0]                   req,
    input  logic                                   abort,
    output logic [LEAVES_PER_TREE*NUM_TREES-1:0]   inlet_open,
    output logic [MIXERS_PER_LEVEL1*NUM_TREES-1:0] leaf_mix_en,
    output logic [MIXERS_PER_LEVEL1*NUM_TREES-1:0] xfer_open,
    output logic [NUM_TREES-1:0]                   root_mix_en,
    output logic [NUM_TREES-1:0]                   outlet_open,
    output logic                                   busy,
    output logic [IDX_W-1:0]                       active_tree,
    output logic [NUM_TREES-1:0]                   done,
    output logic                                   aborted
);

    localparam logic [CNT_W-1:0] LOAD_RL  = CNT_W'(phase_len(LOAD_CYCLES) - 1);
    localparam logic [CNT_W-1:0] MIX_RL   = CNT_W'(phase_len(MIX_CYCLES) - 1);
    localparam logic [CNT_W-1:0] XFER_RL  = CNT_W'(phase_len(XFER_CYCLES) - 1);
    localparam logic [CNT_W-1:0] FLUSH_RL = CNT_W'(phase_len(FLUSH_CYCLES) - 1);

    phase_e                                 state, state_nxt;
    logic [CNT_W-1:0]                       cnt, cnt_nxt;
    logic [IDX_W-1:0]                       ptr, ptr_nxt, tree_nxt;
    logic [IDX_W-1:0]                       grant;
    logic                                   grant_valid;
    logic                                   drain, drain_nxt;

    logic [LEAVES_PER_TREE*NUM_TREES-1:0]   inlet_nxt;
    logic [MIXERS_PER_LEVEL1*NUM_TREES-1:0] leaf_nxt, xfer_nxt;
    logic [NUM_TREES-1:0]                   root_nxt, outlet_nxt, done_nxt;
    logic                                   busy_nxt, aborted_nxt;

    rr_arbiter #(.N(NUM_TREES)) u_arb (
        .req         (req),
        .ptr         (ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Phase state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next phase, counter reload/decrement, grant capture and abort-drain tracking.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        tree_nxt  = active_tree;
        drain_nxt = drain;
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = LOAD;
                    cnt_nxt   = LOAD_RL;
                    tree_nxt  = grant;
                    ptr_nxt   = (grant == IDX_W'(NUM_TREES - 1)) ? '0 : grant + IDX_W'(1);
                    drain_nxt = 1'b0;
                end
            end
            LOAD, MIX_LEAF, XFER, MIX_ROOT: begin
                if (abort) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_RL;
                    drain_nxt = 1'b1;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    unique case (state)
                        LOAD:     begin state_nxt = MIX_LEAF; cnt_nxt = MIX_RL;   end
                        MIX_LEAF: begin state_nxt = XFER;     cnt_nxt = XFER_RL;  end
                        XFER:     begin state_nxt = MIX_ROOT; cnt_nxt = MIX_RL;   end
                        default:  begin state_nxt = FLUSH;    cnt_nxt = FLUSH_RL; end
                    endcase
                end
            end
            FLUSH: begin
                if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                else           state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore decode of the upcoming phase and tree, plus completion pulses.
    always_comb begin
        inlet_nxt   = '0;
        leaf_nxt    = '0;
        xfer_nxt    = '0;
        root_nxt    = '0;
        outlet_nxt  = '0;
        done_nxt    = '0;
        aborted_nxt = 1'b0;
        busy_nxt    = (state_nxt != IDLE);
        unique case (state_nxt)
            LOAD:     inlet_nxt[32'(tree_nxt)*LEAVES_PER_TREE +: LEAVES_PER_TREE]   = '1;
            MIX_LEAF: leaf_nxt[32'(tree_nxt)*MIXERS_PER_LEVEL1 +: MIXERS_PER_LEVEL1] = '1;
            XFER:     xfer_nxt[32'(tree_nxt)*MIXERS_PER_LEVEL1 +: MIXERS_PER_LEVEL1] = '1;
            MIX_ROOT: root_nxt[tree_nxt]   = 1'b1;
            FLUSH:    outlet_nxt[tree_nxt] = 1'b1;
            default:  ;
        endcase
        if (state == FLUSH && cnt == '0) begin
            if (drain) aborted_nxt = 1'b1;
            else       done_nxt[active_tree] = 1'b1;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            ptr         <= '0;
            drain       <= 1'b0;
            active_tree <= '0;
            inlet_open  <= '0;
            leaf_mix_en <= '0;
            xfer_open   <= '0;
            root_mix_en <= '0;
            outlet_open <= '0;
            busy        <= 1'b0;
            done        <= '0;
            aborted     <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            ptr         <= ptr_nxt;
            drain       <= drain_nxt;
            active_tree <= tree_nxt;
            inlet_open  <= inlet_nxt;
            leaf_mix_en <= leaf_nxt;
            xfer_open   <= xfer_nxt;
            root_mix_en <= root_nxt;
            outlet_open <= outlet_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            aborted     <= aborted_nxt;
        end
    end

endmodule

// File: tb/tb_mixer_tree_scheduler.sv
// Directed bench for mixer_tree_scheduler: default-timing instance plus a
// short-phase instance sharing clock and reset.
module tb_mixer_tree_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0, req2 = '0;
    logic        abort = 1'b0, abort2 = 1'b0;

    logic [15:0] inlet, inlet2;
    logic [7:0]  leaf, leaf2, xfer, xfer2;
    logic [3:0]  root, root2, outlet, outlet2, done, done2;
    logic        busy, busy2, aborted, aborted2;
    logic [1:0]  at, at2;

    int n_checks = 0;
    int n_err    = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    mixer_tree_scheduler u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .abort(abort),
        .inlet_open(inlet), .leaf_mix_en(leaf), .xfer_open(xfer),
        .root_mix_en(root), .outlet_open(outlet), .busy(busy),
        .active_tree(at), .done(done), .aborted(aborted)
    );

    mixer_tree_scheduler #(.LOAD_CYCLES(0), .MIX_CYCLES(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .req(req2), .abort(abort2),
        .inlet_open(inlet2), .leaf_mix_en(leaf2), .xfer_open(xfer2),
        .root_mix_en(root2), .outlet_open(outlet2), .busy(busy2),
        .active_tree(at2), .done(done2), .aborted(aborted2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Slice ownership and single-phase-group invariants on both instances.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [15:0] m16;
            logic [7:0]  m8;
            logic [3:0]  m4;
            int          grp;
            m16 = 16'hF << (4 * at); m8 = 8'h3 << (2 * at); m4 = 4'h1 << at;
            chk("mon_slice", 64'(|{inlet & ~m16, leaf & ~m8, xfer & ~m8, root & ~m4, outlet & ~m4}), 64'd0);
            grp = int'(|inlet) + int'(|leaf) + int'(|xfer) + int'(|root) + int'(|outlet);
            chk("mon_groups", 64'(grp > 1), 64'd0);
            m16 = 16'hF << (4 * at2); m8 = 8'h3 << (2 * at2); m4 = 4'h1 << at2;
            chk("mon_slice_fast", 64'(|{inlet2 & ~m16, leaf2 & ~m8, xfer2 & ~m8, root2 & ~m4, outlet2 & ~m4}), 64'd0);
            grp = int'(|inlet2) + int'(|leaf2) + int'(|xfer2) + int'(|root2) + int'(|outlet2);
            chk("mon_groups_fast", 64'(grp > 1), 64'd0);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_main", {inlet, leaf, xfer, root, outlet, busy, at, done, aborted}, 64'd0);
        chk("rst_fast", {inlet2, leaf2, xfer2, root2, outlet2, busy2, at2, done2, aborted2}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Caller has req set in cycle 0; checks cycles 1..57 of a default-timing run.
    task automatic run_tree(input int t, input bit drop_req);
        logic [15:0] ei;
        logic [7:0]  el, ex;
        logic [3:0]  er, eo, ed;
        for (int c = 1; c <= 56; c++) begin
            @(negedge clk);
            if (c == 1 && drop_req) req = '0;
            ei = (c <= 8)             ? 16'hF << (4 * t) : 16'h0;
            el = (c >= 9  && c <= 24) ? 8'h3 << (2 * t)  : 8'h0;
            ex = (c >= 25 && c <= 32) ? 8'h3 << (2 * t)  : 8'h0;
            er = (c >= 33 && c <= 48) ? 4'h1 << t        : 4'h0;
            eo = (c >= 49)            ? 4'h1 << t        : 4'h0;
            chk($sformatf("run t%0d c%0d", t, c),
                {inlet, leaf, xfer, root, outlet, busy, at, done, aborted},
                {ei, el, ex, er, eo, 1'b1, 2'(t), 4'h0, 1'b0});
        end
        @(negedge clk);
        ed = 4'h1 << t;
        chk($sformatf("done t%0d", t), {busy, done, aborted}, {1'b0, ed, 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] ei;
        logic [7:0]  el, ex;
        logic [3:0]  er, eo;

        // Reset, then a single-cycle request from tree 0.
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;
        req = 4'b0001;
        run_tree(0, 1'b1);
        @(negedge clk);
        chk("done_pulse_width", {busy, done}, 5'h0);

        // All trees requesting: round-robin 0,1,2,3,0 with one IDLE cycle between.
        do_reset();
        req = 4'b1111;
        run_tree(0, 1'b0);
        run_tree(1, 1'b0);
        run_tree(2, 1'b0);
        run_tree(3, 1'b0);
        run_tree(0, 1'b0);
        req = '0;
        @(negedge clk);
        chk("rr_stop_idle", {busy, at}, {1'b0, 2'd0});

        // Tree 2 aborted in cycle 10 (MIX_LEAF): drain through FLUSH.
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1)  req = '0;
            if (c == 11) abort = 1'b0;
            ei = (c <= 8)             ? 16'h0F00 : 16'h0;
            el = (c == 9 || c == 10)  ? 8'h30    : 8'h0;
            eo = (c >= 11 && c <= 18) ? 4'h4     : 4'h0;
            chk($sformatf("abort c%0d", c),
                {inlet, leaf, xfer, root, outlet, busy, done, aborted},
                {ei, el, 8'h0, 4'h0, eo, 1'(c <= 18), 4'h0, 1'(c == 19)});
            if (c == 10) abort = 1'b1;
        end
        // Abort while IDLE does nothing.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy, aborted, done}, 6'h0);

        // Synchronous reset during XFER of tree 1, then tree 3 after reset.
        req = 4'b0010;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            if (c == 1) req = '0;
        end
        chk("xfer_before_rst", {xfer, at}, {8'h0C, 2'd1});
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_midrun", {inlet, leaf, xfer, root, outlet, busy, at, done, aborted}, 64'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_quiet", {busy, done, aborted}, 6'h0);
        end
        req = 4'b1000;
        run_tree(3, 1'b1);
        // Pointer is back to 0 after wrapping: tree 1 beats tree 2.
        req = 4'b0110;
        @(negedge clk);
        req = '0;
        chk("ptr_wrap_grant", {at, inlet}, {2'd1, 16'h00F0});
        repeat (56) @(negedge clk);
        chk("ptr_wrap_done", done, 4'b0010);

        // Short phases: LOAD and each MIX stage last one cycle, 19 busy cycles.
        req2 = 4'b0001;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1) req2 = '0;
            ei = (c == 1)             ? 16'h000F : 16'h0;
            el = (c == 2)             ? 8'h03    : 8'h0;
            ex = (c >= 3 && c <= 10)  ? 8'h03    : 8'h0;
            er = (c == 11)            ? 4'h1     : 4'h0;
            eo = (c >= 12 && c <= 19) ? 4'h1     : 4'h0;
            chk($sformatf("fast c%0d", c),
                {inlet2, leaf2, xfer2, root2, outlet2, busy2, done2, aborted2},
                {ei, el, ex, er, eo, 1'(c <= 19), (c == 20) ? 4'h1 : 4'h0, 1'b0});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
